beam_thresh_loader: RTL



---
 rtl/beam_thresh_loader.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/beam_thresh_loader.sv
// Threshold cascade writer for the dual-beam trigger units.
// Holds shadow copies of both per-beam threshold sets. On an apply request
// it streams the selected set(s) into the cascaded threshold chain, beam
// NBEAMS-1 first, then pulses the per-set update strobe.
//
// Ports:
//   clk_i, rst_n_i     clock, synchronous active-low reset
//   reg_addr_i/dat_i   shadow write beam index / threshold value
//   reg_sel_i          shadow bank select (0 = set 0, 1 = set 1)
//   reg_wr_i           shadow write strobe
//   apply_i            per-set load request pulse
//   thresh_o           {set 1 value, set 0 value} shifted into the chain
//   thresh_wr_o        per-set chain shift enable
//   thresh_update_o    per-set apply strobe
//   busy_o / done_o    load in progress / load-complete pulse
//   wr_err_o           sticky: a shadow write was dropped
module beam_thresh_loader #(
  parameter int unsigned       NBEAMS         = 48,
  parameter int unsigned       TBITS          = 18,
  parameter logic [TBITS-1:0]  DEFAULT_THRESH = TBITS'(4000),
  localparam int unsigned      ABITS          = $clog2(NBEAMS)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [ABITS-1:0]     reg_addr_i,
  input  logic [TBITS-1:0]     reg_dat_i,
  input  logic                 reg_sel_i,
  input  logic                 reg_wr_i,
  input  logic [1:0]           apply_i,
  output logic [2*TBITS-1:0]   thresh_o,
  output logic [1:0]           thresh_wr_o,
  output logic [1:0]           thresh_update_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 wr_err_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_SHIFT  = 3'd2;
  localparam logic [2:0] S_UPDATE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // Power-up contents come from the declaration; reset leaves them alone.
  logic [TBITS-1:0] bank0 [NBEAMS] = '{default: DEFAULT_THRESH};
  logic [TBITS-1:0] bank1 [NBEAMS] = '{default: DEFAULT_THRESH};

  logic [2:0]         state_q, state_d;
  logic [ABITS-1:0]   addr_q, addr_d;
  logic               last_q, last_d;
  logic [1:0]         mask_q, mask_d;
  logic [1:0]         pend_q, pend_d;
  logic [2*TBITS-1:0] thresh_d;
  logic [1:0]         wr_d, upd_d;
  logic               busy_d, done_d, err_d;

  logic               addr_ok, bank_busy, wr_ok, wr_drop;
  logic [2*TBITS-1:0] rd_data;

  // Shadow write admission: in range, and not into a bank being streamed.
  assign addr_ok   = {1'b0, reg_addr_i} < (ABITS+1)'(NBEAMS);
  assign bank_busy = (state_q != S_IDLE) && mask_q[reg_sel_i];
  assign wr_ok     = reg_wr_i && addr_ok && !bank_busy;
  assign wr_drop   = reg_wr_i && !wr_ok;

  // Read port; thresh_o is its output register. Masked-off sets read as 0.
  assign rd_data = {mask_q[1] ? bank1[addr_q] : {TBITS{1'b0}},
                    mask_q[0] ? bank0[addr_q] : {TBITS{1'b0}}};

  // Shadow RAM write port
  always_ff @(posedge clk_i) begin
    if (wr_ok && !reg_sel_i) bank0[reg_addr_i] <= reg_dat_i;
    if (wr_ok &&  reg_sel_i) bank1[reg_addr_i] <= reg_dat_i;
  end

  // Next state and next registered outputs
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    last_d   = last_q;
    mask_d   = mask_q;
    pend_d   = pend_q | apply_i;
    thresh_d = '0;
    wr_d     = 2'b00;
    upd_d    = 2'b00;
    done_d   = 1'b0;
    err_d    = wr_err_o;

    case (state_q)
      S_IDLE: begin
        if ((apply_i | pend_q) != 2'b00) begin
          mask_d  = apply_i | pend_q;
          pend_d  = 2'b00;
          err_d   = 1'b0;
          addr_d  = ABITS'(NBEAMS - 1);
          last_d  = 1'b0;
          state_d = S_READ;
        end
      end
      // READ issues the first (beam NBEAMS-1) read; SHIFT keeps the stream
      // gapless and leaves one cycle after beam 0 has been presented.
      S_READ, S_SHIFT: begin
        if (last_q) begin
          upd_d   = mask_q;
          state_d = S_UPDATE;
        end else begin
          thresh_d = rd_data;
          wr_d     = mask_q;
          addr_d   = addr_q - 1'b1;
          last_d   = (addr_q == '0);
          state_d  = S_SHIFT;
        end
      end
      S_UPDATE: begin
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (wr_drop) err_d = 1'b1;
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      last_q          <= 1'b0;
      mask_q          <= 2'b00;
      pend_q          <= 2'b00;
      thresh_o        <= '0;
      thresh_wr_o     <= 2'b00;
      thresh_update_o <= 2'b00;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      wr_err_o        <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      last_q          <= last_d;
      mask_q          <= mask_d;
      pend_q          <= pend_d;
      thresh_o        <= thresh_d;
      thresh_wr_o     <= wr_d;
      thresh_update_o <= upd_d;
      busy_o          <= busy_d;
      done_o          <= done_d;
      wr_err_o        <= err_d;
    end
  end

endmodule
